// File: rtl/lcd_pixel_fifo_if.sv
// Pixel FIFO bus between the GPU rasteriser (push side), the LCD pixel
// writer (pop side) and the debug flag logic.
interface lcd_pixel_fifo_if #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH_LOG2 = 9
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_sof;
    logic                  full;
    logic                  almost_full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_sof;
    logic                  empty;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;
    logic                  underflow;
    logic                  clear_flags;

    modport master (
        output wr_en, wr_data, wr_sof, rd_en, clear_flags,
        input  full, almost_full, rd_data, rd_sof, empty, level, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, wr_sof, rd_en, clear_flags,
        output full, almost_full, rd_data, rd_sof, empty, level, overflow, underflow
    );
endinterface

// File: rtl/lcd_pixel_fifo.sv
// First-word-fall-through pixel FIFO feeding the LCD pixel writer.
// Data path: synchronous-read array -> prefetch register -> head register.
// The prefetch stage lets a pop on every clock be refilled without a bubble.
// Capacity counts array plus head (2^DEPTH_LOG2 + 1); the prefetch slot is
// covered because its array entry is released as soon as the read issues.
module lcd_pixel_fifo #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH_LOG2 = 9,
    parameter int AF_MARGIN  = 16
) (
    input  logic            CLOCK_50,
    input  logic            RESET_N,
    lcd_pixel_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    localparam logic [LW-1:0]         CAPACITY = LW'(DEPTH + 1);
    localparam logic [LW-1:0]         AF_LEVEL = LW'(DEPTH + 1 - AF_MARGIN);
    localparam logic [LW-1:0]         CNT_ONE  = LW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [DATA_WIDTH:0]   r_mem [DEPTH];
    logic [DATA_WIDTH:0]   r_pf_data;
    logic                  r_pf_valid;
    logic [DATA_WIDTH-1:0] r_head_data;
    logic                  r_head_sof;
    logic                  r_head_valid;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [LW-1:0]         r_mem_cnt;
    logic [LW-1:0]         r_level;
    logic                  r_full;
    logic                  r_almost_full;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_head_load;
    logic                  w_rd_issue;
    logic [LW-1:0]         w_level_nxt;
    logic [LW-1:0]         w_mem_cnt_nxt;

    // Accepted transfers; a full FIFO drops the push even when a pop happens
    // in the same cycle.
    assign w_push      = bus.wr_en & ~r_full;
    assign w_pop       = bus.rd_en & r_head_valid;
    assign w_head_load = r_pf_valid & (~r_head_valid | w_pop);
    // Only entries written on an earlier edge are read, so the array never
    // sees a read and write of the same live slot.
    assign w_rd_issue  = (r_mem_cnt != '0) & (~r_pf_valid | w_head_load);

    // Occupancy bookkeeping for the whole FIFO and for the array alone.
    always_comb begin
        w_level_nxt   = r_level;
        w_mem_cnt_nxt = r_mem_cnt;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - CNT_ONE;
        end
        if (w_push && !w_rd_issue) begin
            w_mem_cnt_nxt = r_mem_cnt + CNT_ONE;
        end else if (!w_push && w_rd_issue) begin
            w_mem_cnt_nxt = r_mem_cnt - CNT_ONE;
        end
    end

    // Array write port and synchronous read into the prefetch data register.
    always_ff @(posedge CLOCK_50) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.wr_sof, bus.wr_data};
        end
        if (w_rd_issue) begin
            r_pf_data <= r_mem[r_rd_ptr];
        end
    end

    // Pointers, prefetch/head stages, level, status and sticky debug flags.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_mem_cnt     <= '0;
            r_pf_valid    <= 1'b0;
            r_head_valid  <= 1'b0;
            r_head_data   <= '0;
            r_head_sof    <= 1'b0;
            r_level       <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_issue) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_mem_cnt <= w_mem_cnt_nxt;

            if (w_rd_issue) begin
                r_pf_valid <= 1'b1;
            end else if (w_head_load) begin
                r_pf_valid <= 1'b0;
            end

            // Head data is left untouched on a pop with nothing behind it,
            // so rd_data holds the last pixel shown.
            if (w_head_load) begin
                r_head_valid <= 1'b1;
                r_head_data  <= r_pf_data[DATA_WIDTH-1:0];
                r_head_sof   <= r_pf_data[DATA_WIDTH];
            end else if (w_pop) begin
                r_head_valid <= 1'b0;
            end

            r_level       <= w_level_nxt;
            r_full        <= (w_level_nxt == CAPACITY);
            r_almost_full <= (w_level_nxt >= AF_LEVEL);

            // A new violation wins over a clear in the same cycle.
            if (bus.wr_en && r_full) begin
                r_overflow <= 1'b1;
            end else if (bus.clear_flags) begin
                r_overflow <= 1'b0;
            end
            if (bus.rd_en && !r_head_valid) begin
                r_underflow <= 1'b1;
            end else if (bus.clear_flags) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign bus.full        = r_full;
    assign bus.almost_full = r_almost_full;
    assign bus.rd_data     = r_head_data;
    assign bus.rd_sof      = r_head_sof;
    assign bus.empty       = ~r_head_valid;
    assign bus.level       = r_level;
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;
endmodule

// File: tb/tb_lcd_pixel_fifo.sv
// Bench for lcd_pixel_fifo. Reference model: a queue of pixels, each tagged
// with the edge that accepted it; a pixel reaches the head two edges after
// its push and otherwise as soon as the pixel ahead of it is popped.
module tb_lcd_pixel_fifo;
    localparam int DW  = 24;
    localparam int DL  = 9;
    localparam int AFM = 16;
    localparam int CAP = (1 << DL) + 1;
    localparam logic [39:0] RESET_VEC = 40'h80_0000_0000;

    logic CLOCK_50 = 1'b0;
    logic RESET_N  = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    lcd_pixel_fifo_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) bus ();

    lcd_pixel_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .AF_MARGIN(AFM)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .bus      (bus)
    );

    typedef struct {
        logic [23:0] d;
        logic        s;
        int          t;
    } pix_t;

    pix_t        q[$];
    int          edge_n = 0;
    logic [23:0] m_shown;
    logic        m_shown_sof;
    logic        m_ovf;
    logic        m_unf;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic bit m_visible();
        return (q.size() > 0) && (q[0].t + 2 <= edge_n);
    endfunction

    // {empty, full, almost_full, overflow, underflow, rd_sof, rd_data, level}
    function automatic logic [39:0] m_out();
        bit v;
        v = m_visible();
        return {~v, q.size() == CAP, q.size() >= CAP - AFM, m_ovf, m_unf,
                m_shown_sof, m_shown, 10'(q.size())};
    endfunction

    function automatic logic [39:0] dut_out();
        return {bus.empty, bus.full, bus.almost_full, bus.overflow, bus.underflow,
                bus.rd_sof, bus.rd_data, bus.level};
    endfunction

    task automatic model_reset();
        q.delete();
        m_shown     = '0;
        m_shown_sof = 1'b0;
        m_ovf       = 1'b0;
        m_unf       = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.wr_en       = 1'b0;
        bus.wr_data     = '0;
        bus.wr_sof      = 1'b0;
        bus.rd_en       = 1'b0;
        bus.clear_flags = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        RESET_N = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #3;
        model_reset();
        RESET_N = 1'b1;
    endtask

    // One clock: drive inputs, take the edge, advance the model, settle #1.
    task automatic tick(input bit we, input logic [23:0] wd, input bit ws,
                        input bit re, input bit clr);
        bit full_pre;
        bit vis_pre;
        pix_t p;
        bus.wr_en       = we;
        bus.wr_data     = wd;
        bus.wr_sof      = ws;
        bus.rd_en       = re;
        bus.clear_flags = clr;
        full_pre = (q.size() == CAP);
        vis_pre  = m_visible();
        @(posedge CLOCK_50);
        edge_n++;
        if (re && vis_pre) begin
            p = q.pop_front();
        end
        if (we && !full_pre) begin
            q.push_back('{wd, ws, edge_n});
        end
        if (we && full_pre) m_ovf = 1'b1;
        else if (clr)       m_ovf = 1'b0;
        if (re && !vis_pre) m_unf = 1'b1;
        else if (clr)       m_unf = 1'b0;
        if (m_visible()) begin
            m_shown     = q[0].d;
            m_shown_sof = q[0].s;
        end
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_vec++;
        if (dut_out() !== RESET_VEC) begin
            n_err++;
            $display("FAIL reset_idle got %h exp %h", dut_out(), RESET_VEC);
        end
        tick(1'b1, 24'h45c487, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (dut_out() !== {1'b1, 5'b0, 24'h0, 10'd1}) begin
            n_err++;
            $display("FAIL first_push_edge1 got %h exp %h", dut_out(), {1'b1, 5'b0, 24'h0, 10'd1});
        end
        tick(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (dut_out() !== {1'b1, 5'b0, 24'h0, 10'd1}) begin
            n_err++;
            $display("FAIL first_push_edge2 got %h exp %h", dut_out(), {1'b1, 5'b0, 24'h0, 10'd1});
        end
        tick(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (dut_out() !== {1'b0, 5'b0, 24'h45c487, 10'd1}) begin
            n_err++;
            $display("FAIL first_push_edge3 got %h exp %h", dut_out(), {1'b0, 5'b0, 24'h45c487, 10'd1});
        end
    endtask

    task automatic test_fill_drain();
        int first_af = -1;
        int k = 0;
        apply_reset();
        for (int i = 0; i < 520; i++) begin
            tick(1'b1, 24'(i), 1'b0, 1'b0, 1'b0);
            n_vec++;
            if (dut_out() !== m_out()) begin
                n_err++;
                $display("FAIL fill_vec push %0d got %h exp %h", i, dut_out(), m_out());
            end
            if (bus.almost_full && first_af < 0) first_af = int'(bus.level);
            if (i == 512) begin
                n_vec++;
                if (bus.full !== 1'b1) begin
                    n_err++;
                    $display("FAIL full_at_513 got %b exp 1", bus.full);
                end
            end
        end
        n_vec++;
        if (first_af != 497) begin
            n_err++;
            $display("FAIL af_first_level got %0d exp 497", first_af);
        end
        n_vec++;
        if (bus.overflow !== 1'b1) begin
            n_err++;
            $display("FAIL fill_overflow got %b exp 1", bus.overflow);
        end
        for (int c = 0; c < 1200 && k < CAP; c++) begin
            if (bus.empty === 1'b0) begin
                n_vec++;
                if (bus.rd_data !== 24'(k)) begin
                    n_err++;
                    $display("FAIL drain_order idx %0d got %h exp %h", k, bus.rd_data, 24'(k));
                end
                k++;
            end
            tick(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
            n_vec++;
            if (dut_out() !== m_out()) begin
                n_err++;
                $display("FAIL drain_vec cyc %0d got %h exp %h", c, dut_out(), m_out());
            end
        end
        n_vec++;
        if (k != CAP) begin
            n_err++;
            $display("FAIL drain_count got %0d exp %0d", k, CAP);
        end
        n_vec++;
        if ({bus.empty, bus.level} !== {1'b1, 10'd0}) begin
            n_err++;
            $display("FAIL drain_empty got empty %b level %0d exp 1 0", bus.empty, bus.level);
        end
    endtask

    task automatic test_back_to_back();
        int pops = 0;
        int sof_idx[$];
        apply_reset();
        for (int c = 0; c < 2000; c++) begin
            if (bus.empty === 1'b0) begin
                if (bus.rd_sof === 1'b1) sof_idx.push_back(pops);
                pops++;
            end
            tick(1'b1, 24'($urandom), (c % 800) == 0, 1'b1, 1'b0);
            n_vec++;
            if (dut_out() !== m_out()) begin
                n_err++;
                $display("FAIL stream_vec cyc %0d got %h exp %h", c, dut_out(), m_out());
            end
            if (c >= 5) begin
                n_vec++;
                if (bus.empty !== 1'b0) begin
                    n_err++;
                    $display("FAIL stream_gap cyc %0d got empty %b exp 0", c, bus.empty);
                end
            end
        end
        n_vec++;
        if (sof_idx.size() != 3 || sof_idx[0] != 0 || sof_idx[1] != 800 || sof_idx[2] != 1600) begin
            n_err++;
            $display("FAIL stream_sof got %0d markers (%p) exp 0,800,1600", sof_idx.size(), sof_idx);
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        tick(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (bus.underflow !== 1'b1) begin
            n_err++;
            $display("FAIL underflow_set got %b exp 1", bus.underflow);
        end
        tick(1'b0, 24'h0, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if (bus.underflow !== 1'b1) begin
            n_err++;
            $display("FAIL underflow_set_beats_clear got %b exp 1", bus.underflow);
        end
        tick(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (bus.underflow !== 1'b0) begin
            n_err++;
            $display("FAIL underflow_clear got %b exp 0", bus.underflow);
        end
        n_vec++;
        if (dut_out() !== m_out()) begin
            n_err++;
            $display("FAIL underflow_vec got %h exp %h", dut_out(), m_out());
        end
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        for (int i = 0; i < CAP; i++) tick(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b0);
        tick(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({bus.full, bus.level} !== {1'b1, 10'd513}) begin
            n_err++;
            $display("FAIL full_level got full %b level %0d exp 1 513", bus.full, bus.level);
        end
        tick(1'b1, 24'habcdef, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if ({bus.full, bus.overflow, bus.level} !== {1'b0, 1'b1, 10'd512}) begin
            n_err++;
            $display("FAIL full_push_pop got full %b ovf %b level %0d exp 0 1 512",
                     bus.full, bus.overflow, bus.level);
        end
        n_vec++;
        if (dut_out() !== m_out()) begin
            n_err++;
            $display("FAIL full_push_pop_vec got %h exp %h", dut_out(), m_out());
        end
    endtask

    task automatic test_random();
        int wp;
        int rp;
        apply_reset();
        for (int c = 0; c < 3200; c++) begin
            if (((c / 800) % 2) == 0) begin
                wp = 95; rp = 20;
            end else begin
                wp = 15; rp = 95;
            end
            tick($urandom_range(99) < wp, 24'($urandom), $urandom_range(99) < 5,
                 $urandom_range(99) < rp, $urandom_range(99) < 2);
            n_vec++;
            if (dut_out() !== m_out()) begin
                n_err++;
                $display("FAIL random_vec cyc %0d got %h exp %h", c, dut_out(), m_out());
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int c = 0; c < 2000 && q.size() < 200; c++) begin
            tick(1'b1, 24'($urandom), 1'b0, $urandom_range(99) < 30, 1'b0);
        end
        n_vec++;
        if (bus.level !== 10'd200) begin
            n_err++;
            $display("FAIL midstream_level got %0d exp 200", bus.level);
        end
        #3;
        idle_inputs();
        RESET_N = 1'b0;
        #1;
        n_vec++;
        if (dut_out() !== RESET_VEC) begin
            n_err++;
            $display("FAIL async_reset_immediate got %h exp %h", dut_out(), RESET_VEC);
        end
        repeat (2) @(posedge CLOCK_50);
        #3;
        model_reset();
        RESET_N = 1'b1;
        tick(1'b1, 24'h5a5a5a, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (dut_out() !== {1'b0, 4'b0, 1'b1, 24'h5a5a5a, 10'd1}) begin
            n_err++;
            $display("FAIL post_reset_readback got %h exp %h", dut_out(),
                     {1'b0, 4'b0, 1'b1, 24'h5a5a5a, 10'd1});
        end
        tick(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if ({bus.empty, bus.level} !== {1'b1, 10'd0}) begin
            n_err++;
            $display("FAIL post_reset_drain got empty %b level %0d exp 1 0", bus.empty, bus.level);
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_underflow();
        test_full_push_pop();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout after %0d vectors", n_vec);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lcd_pixel_fifo.md
# lcd_pixel_fifo

Pixel buffer that sits directly upstream of the LCD pixel writer. The GPU rasteriser side pushes 24-bit RGB pixels tagged with a start-of-frame marker. The pixel writer pops one pixel per active dot clock using the `empty` flag and RGB output it already expects. Single clock domain, first-word-fall-through read, with sticky overflow/underflow flags for debug on the GPIO headers.

## Interface
- `DATA_WIDTH`, 24: RGB pixel width; bit 23:16 R, 15:8 G, 7:0 B.
- `DEPTH_LOG2`, 9: storage depth is 2^DEPTH_LOG2 entries (512).
- `AF_MARGIN`, 16: `almost_full` asserts when free slots ≤ AF_MARGIN.
- `CLOCK_50`  in  1  system clock; all logic on rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  push request.
- `wr_data`  in  DATA_WIDTH  pixel to push.
- `wr_sof`  in  1  pushed pixel is first pixel of a frame.
- `full`  out  1  no free slot; push is dropped.
- `almost_full`  out  1  free slots ≤ AF_MARGIN.
- `rd_en`  in  1  pop request from pixel writer.
- `rd_data`  out  DATA_WIDTH  head pixel; valid while `empty`=0.
- `rd_sof`  out  1  SOF tag of head pixel.
- `empty`  out  1  no pixel at head.
- `level`  out  DEPTH_LOG2+1  total pixels held (array + head register).
- `overflow`  out  1  sticky: push attempted while full.
- `underflow`  out  1  sticky: pop attempted while empty.
- `clear_flags`  in  1  clears both sticky flags.

## Operation
- Storage: 2^DEPTH_LOG2 × (DATA_WIDTH+1) synchronous-read array (SOF bit stored alongside pixel) plus one head register (FWFT stage). Total capacity = 2^DEPTH_LOG2 + 1; `full` when `level` = capacity.
- Pointers `wr_ptr`, `rd_ptr` are DEPTH_LOG2 bits and wrap modulo depth with no special handling.
- Push: when `wr_en`=1 and `full`=0, write {wr_sof, wr_data} at `wr_ptr`, increment `wr_ptr`. When `full`=1, data is dropped, pointers unchanged, `overflow` set. This holds even with a simultaneous pop.
- Pop: when `rd_en`=1 and `empty`=0, the head register is consumed. When `rd_en`=1 and `empty`=1, nothing changes and `underflow` is set.
- Head refill: the head register loads the array read result whenever it is empty or being popped and the array holds data. The array read is issued one cycle earlier (prefetch valid bit), so a back-to-back pop sustains 1 pixel/clock.
- `level`: +1 on accepted push, −1 on accepted pop, unchanged when both occur. Never exceeds capacity or goes below 0.
- `almost_full` = (capacity − level) ≤ AF_MARGIN, registered with `level`.
- Sticky flags: set has priority over `clear_flags` in the same cycle.
- Reset (any time, including mid-frame): pointers 0, level 0, head invalid. Outputs: `empty`=1, `full`=0, `almost_full`=0, `rd_data`=0, `rd_sof`=0, `level`=0, `overflow`=0, `underflow`=0. Contents are discarded.

## Timing
- All outputs are registered. No combinational path from `wr_en`/`rd_en` to any output.
- Write-to-read latency into an empty FIFO: a push on edge k gives `empty`=0 with valid `rd_data` after edge k+2.
- `full` asserts after the edge that accepts the push reaching capacity. It deasserts after the edge that accepts the next pop.
- A pop on edge k presents the next pixel after edge k if the array already prefetched it. Steady-state throughput is 1 push and 1 pop per clock.
- `rd_data`/`rd_sof` hold their value while `rd_en`=0.

## Test plan
- Reset then idle → `empty`=1, `level`=0, all flags 0. Push 0x45c487 at edge 1 → `empty`=0 after edge 3, `rd_data`=0x45c487, `level`=1.
- Push 520 sequential values 0..519 with no pops → `full`=1 after the 513th push. `almost_full` is first seen at level 497. Pushes 514–520 are dropped, `overflow`=1. Then pop all → exactly 0..512 returned in order, `empty`=1 afterwards.
- Continuous push+pop for 2000 cycles with `wr_sof` on every 800th pixel → no gaps after fill, `level` constant, `rd_sof` high exactly on pixels 0, 800, 1600. Pointer wrap produces no corruption.
- Pop while empty → `underflow`=1. Assert `clear_flags` and a new underflow pop in the same cycle → `underflow` stays 1. Next cycle `clear_flags` alone → 0.
- Full FIFO with simultaneous push+pop → push dropped, `overflow`=1, `level` = 512.
- Assert `RESET_N`=0 mid-stream at level 200 → outputs return to reset values immediately, without waiting for a clock edge. After release, the first new push reads back correctly with no stale data.
